// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared encodings and the decode-control bundle carried down the E/M/W pipeline.
package hazard_ctrl_pipe_pkg;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } forward_e;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       alu_src;
      logic [2:0] alu_control;
   } ctrl_t;

endpackage

// File: rtl/hazard_ctrl_pipe_hazard_unit.sv
// Combinational stall/flush/forward generation. FORWARDING_EN selects
// bypass + load-use stall; otherwise every in-flight RAW dependency stalls.
module hazard_unit
   import hazard_ctrl_pipe_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] rs1d,
   input  logic [REG_W-1:0] rs2d,
   input  logic [REG_W-1:0] rs1e,
   input  logic [REG_W-1:0] rs2e,
   input  logic [REG_W-1:0] rde,
   input  logic [REG_W-1:0] rdm,
   input  logic [REG_W-1:0] rdw,
   input  logic             regwritee,
   input  logic             regwritem,
   input  logic             regwritew,
   input  logic [1:0]       resultsrce,
   input  logic             pcsrce,
   output logic             stallf,
   output logic             stalld,
   output logic             flushd,
   output logic             flushe,
   output logic [1:0]       forwardae,
   output logic [1:0]       forwardbe
);

   logic hazard;

`ifdef FORWARDING_EN
   logic lw_stall;

   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                          input logic             rw_m,
                                          input logic [REG_W-1:0] rd_m,
                                          input logic             rw_w,
                                          input logic [REG_W-1:0] rd_w);
      if (rw_m && (rd_m != '0) && (rd_m == src))
         return FWD_M;
      else if (rw_w && (rd_w != '0) && (rd_w == src))
         return FWD_W;
      else
         return FWD_RF;
   endfunction

   assign lw_stall = (resultsrce == RES_LOAD) && (rde != '0) &&
                     ((rde == rs1d) || (rde == rs2d));
   assign hazard   = lw_stall;

   always_comb begin
      forwardae = fwd_sel(rs1e, regwritem, rdm, regwritew, rdw);
      forwardbe = fwd_sel(rs2e, regwritem, rdm, regwritew, rdw);
   end
`else
   logic unused_fwd;

   function automatic logic raw_hit(input logic [REG_W-1:0] src,
                                    input logic             rw_e,
                                    input logic [REG_W-1:0] rd_e,
                                    input logic             rw_m,
                                    input logic [REG_W-1:0] rd_m);
      return (src != '0) && ((rw_e && (rd_e == src)) || (rw_m && (rd_m == src)));
   endfunction

   assign hazard = raw_hit(rs1d, regwritee, rde, regwritem, rdm) |
                   raw_hit(rs2d, regwritee, rde, regwritem, rdm);

   assign forwardae  = FWD_RF;
   assign forwardbe  = FWD_RF;
   assign unused_fwd = ^{rs1e, rs2e, rdw, regwritew, resultsrce};
`endif

   // A taken redirect squashes the stalled instruction, so it must not stall.
   assign stallf = hazard & ~pcsrce;
   assign stalld = hazard & ~pcsrce;
   assign flushd = pcsrce;
   assign flushe = hazard | pcsrce;

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// E/M/W control pipeline with hazard detection; define FORWARDING_EN to enable
// operand bypassing (otherwise RAW dependencies stall until written back).
module hazard_ctrl_pipe
   import hazard_ctrl_pipe_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RegWriteD,
   input  logic             MemWriteD,
   input  logic             JumpD,
   input  logic             BranchD,
   input  logic             ALUSrcD,
   input  logic [1:0]       ResultSrcD,
   input  logic [2:0]       ALUControlD,
   input  logic [REG_W-1:0] Rs1D,
   input  logic [REG_W-1:0] Rs2D,
   input  logic [REG_W-1:0] RdD,
   input  logic             ZeroE,
   output logic             ALUSrcE,
   output logic [2:0]       ALUControlE,
   output logic             MemWriteM,
   output logic             RegWriteW,
   output logic [1:0]       ResultSrcW,
   output logic [REG_W-1:0] RdW,
   output logic             PCSrcE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE
);

   ctrl_t            ctrl_d, ctrl_e, ctrl_m, ctrl_w;
   logic [REG_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic             unused_w;

   always_comb begin
      ctrl_d             = '0;
      ctrl_d.reg_write   = RegWriteD;
      ctrl_d.result_src  = ResultSrcD;
      ctrl_d.mem_write   = MemWriteD;
      ctrl_d.jump        = JumpD;
      ctrl_d.branch      = BranchD;
      ctrl_d.alu_src     = ALUSrcD;
      ctrl_d.alu_control = ALUControlD;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_e <= '0;
         rs1_e  <= '0;
         rs2_e  <= '0;
         rd_e   <= '0;
         ctrl_m <= '0;
         rd_m   <= '0;
         ctrl_w <= '0;
         rd_w   <= '0;
      end else begin
         if (FlushE) begin
            ctrl_e <= '0;
            rs1_e  <= '0;
            rs2_e  <= '0;
            rd_e   <= '0;
         end else begin
            ctrl_e <= ctrl_d;
            rs1_e  <= Rs1D;
            rs2_e  <= Rs2D;
            rd_e   <= RdD;
         end
         ctrl_m <= ctrl_e;
         rd_m   <= rd_e;
         ctrl_w <= ctrl_m;
         rd_w   <= rd_m;
      end
   end

   assign PCSrcE      = (ctrl_e.branch & ZeroE) | ctrl_e.jump;
   assign ALUSrcE     = ctrl_e.alu_src;
   assign ALUControlE = ctrl_e.alu_control;
   assign MemWriteM   = ctrl_m.mem_write;
   assign RegWriteW   = ctrl_w.reg_write;
   assign ResultSrcW  = ctrl_w.result_src;
   assign RdW         = rd_w;

   // W only needs the write-back fields; the rest are carried for completeness.
   assign unused_w = ^{ctrl_w.mem_write, ctrl_w.jump, ctrl_w.branch,
                       ctrl_w.alu_src, ctrl_w.alu_control};

   hazard_unit #(.REG_W(REG_W)) u_hazard (
      .rs1d       (Rs1D),
      .rs2d       (Rs2D),
      .rs1e       (rs1_e),
      .rs2e       (rs2_e),
      .rde        (rd_e),
      .rdm        (rd_m),
      .rdw        (rd_w),
      .regwritee  (ctrl_e.reg_write),
      .regwritem  (ctrl_m.reg_write),
      .regwritew  (ctrl_w.reg_write),
      .resultsrce (ctrl_e.result_src),
      .pcsrce     (PCSrcE),
      .stallf     (StallF),
      .stalld     (StallD),
      .flushd     (FlushD),
      .flushe     (FlushE),
      .forwardae  (ForwardAE),
      .forwardbe  (ForwardBE)
   );

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Scoreboard bench: a stage-list reference model predicts all outputs each cycle;
// a negedge monitor compares. Works with or without FORWARDING_EN.
module tb_hazard_ctrl_pipe;

   localparam int REG_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
   logic [1:0]       ResultSrcD;
   logic [2:0]       ALUControlD;
   logic [REG_W-1:0] Rs1D, Rs2D, RdD;
   logic             ZeroE;
   logic             ALUSrcE;
   logic [2:0]       ALUControlE;
   logic             MemWriteM, RegWriteW;
   logic [1:0]       ResultSrcW;
   logic [REG_W-1:0] RdW;
   logic             PCSrcE, StallF, StallD, FlushD, FlushE;
   logic [1:0]       ForwardAE, ForwardBE;

   hazard_ctrl_pipe #(.REG_W(REG_W)) dut (
      .clk(clk), .reset(reset),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
      .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
      .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .ZeroE(ZeroE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
      .RdW(RdW), .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       rw;
      bit [1:0] rsrc;
      bit       mw, j, b, as;
      bit [2:0] alu;
      bit [4:0] rs1, rs2, rd;
   } instr_t;

   // Model pipeline: stage[0]=E, stage[1]=M, stage[2]=W
   instr_t    stage[3];
   instr_t    cur_d;
   bit        cur_z, cur_rst, last_stall;
   logic [21:0] expq[$];
   int        checks = 0;
   int        errors = 0;

   function automatic instr_t mk(bit rw, bit [1:0] rsrc, bit mw, bit j, bit b,
                                 bit as, bit [2:0] alu, bit [4:0] rs1,
                                 bit [4:0] rs2, bit [4:0] rd);
      instr_t i;
      i.rw = rw; i.rsrc = rsrc; i.mw = mw; i.j = j; i.b = b; i.as = as;
      i.alu = alu; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
      return i;
   endfunction

   function automatic instr_t nop();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic bit m_pcsrc();
      return (stage[0].b && cur_z) || stage[0].j;
   endfunction

   function automatic bit m_hazard();
`ifdef FORWARDING_EN
      return stage[0].rsrc == 2'b01 && stage[0].rd != 0 &&
             (stage[0].rd == cur_d.rs1 || stage[0].rd == cur_d.rs2);
`else
      bit h = 0;
      bit [4:0] srcs[2];
      srcs[0] = cur_d.rs1; srcs[1] = cur_d.rs2;
      foreach (srcs[k])
         if (srcs[k] != 0 && ((stage[0].rw && stage[0].rd == srcs[k]) ||
                              (stage[1].rw && stage[1].rd == srcs[k])))
            h = 1;
      return h;
`endif
   endfunction

   function automatic bit [1:0] m_fwd(bit [4:0] src);
`ifdef FORWARDING_EN
      if (stage[1].rw && stage[1].rd != 0 && stage[1].rd == src) return 2'b10;
      if (stage[2].rw && stage[2].rd != 0 && stage[2].rd == src) return 2'b01;
`endif
      return 2'b00;
   endfunction

   function automatic logic [21:0] m_expect();
      bit p = m_pcsrc();
      bit h = m_hazard();
      bit st = h && !p;
      return {stage[0].as, stage[0].alu, stage[1].mw, stage[2].rw, stage[2].rsrc,
              stage[2].rd, p, st, st, p, h || p,
              m_fwd(stage[0].rs1), m_fwd(stage[0].rs2)};
   endfunction

   // Instructions advance one stage per edge; a flush turns the E entry into a bubble.
   task automatic model_edge();
      bit fl = m_hazard() || m_pcsrc();
      if (cur_rst) begin
         foreach (stage[k]) stage[k] = nop();
      end else begin
         stage[2] = stage[1];
         stage[1] = stage[0];
         stage[0] = fl ? nop() : cur_d;
      end
   endtask

   task automatic step(input instr_t d, input bit z, input bit r);
      @(posedge clk);
      model_edge();
      #1;
      cur_d = d; cur_z = z; cur_rst = r;
      reset = r;
      RegWriteD = d.rw; ResultSrcD = d.rsrc; MemWriteD = d.mw; JumpD = d.j;
      BranchD = d.b; ALUSrcD = d.as; ALUControlD = d.alu;
      Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd; ZeroE = z;
      last_stall = m_hazard() && !m_pcsrc() && !r;
      expq.push_back(m_expect());
   endtask

   // A stalled D instruction is held upstream, so re-present it until it moves on.
   task automatic issue(input instr_t d, input bit z);
      int tries = 0;
      step(d, z, 0);
      while (last_stall && tries < 4) begin
         step(d, z, 0);
         tries++;
      end
   endtask

   task automatic do_reset();
      step(nop(), 0, 1);
      step(nop(), 0, 1);
   endtask

   initial begin : monitor
      logic [21:0] act, exp_v;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            exp_v = expq.pop_front();
            act = {ALUSrcE, ALUControlE, MemWriteM, RegWriteW, ResultSrcW, RdW,
                   PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
            checks++;
            if (act !== exp_v) begin
               errors++;
               $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, exp_v);
            end
         end
      end
   end

   initial begin : stim
      foreach (stage[k]) stage[k] = nop();
      cur_d = nop(); cur_z = 0; cur_rst = 1; last_stall = 0;
      reset = 1; RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
      ResultSrcD = 0; ALUControlD = 0; Rs1D = 0; Rs2D = 0; RdD = 0; ZeroE = 0;

      // back-to-back dependency: add x5 ; add x6,x5,x1
      do_reset();
      issue(mk(1, 0, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5), 0);
      issue(mk(1, 0, 0, 0, 0, 0, 3'd0, 5'd5, 5'd1, 5'd6), 0);
      repeat (4) issue(nop(), 0);
      // add x5 ; nop ; sub x7,x2,x5
      issue(mk(1, 0, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5), 0);
      issue(nop(), 0);
      issue(mk(1, 0, 0, 0, 0, 0, 3'd1, 5'd2, 5'd5, 5'd7), 0);
      repeat (4) issue(nop(), 0);
      // load-use: lw x5 ; add x6,x5,x5
      issue(mk(1, 2'b01, 0, 0, 0, 1, 3'd0, 5'd1, 5'd0, 5'd5), 0);
      issue(mk(1, 0, 0, 0, 0, 0, 3'd0, 5'd5, 5'd5, 5'd6), 0);
      repeat (4) issue(nop(), 0);
      // taken beq followed by a candidate that must be bubbled
      issue(mk(0, 0, 0, 0, 1, 0, 3'd1, 5'd1, 5'd2, 5'd0), 0);
      issue(mk(1, 0, 0, 0, 0, 1, 3'd7, 5'd3, 5'd4, 5'd9), 1);
      repeat (3) issue(nop(), 0);
      // jal x5 in E while D reads x5
      issue(mk(1, 2'b10, 0, 1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd5), 0);
      issue(mk(1, 0, 0, 0, 0, 0, 3'd0, 5'd5, 5'd0, 5'd8), 0);
      repeat (3) issue(nop(), 0);
      // reset with lw in M and store in E
      issue(mk(1, 2'b01, 0, 0, 0, 1, 3'd0, 5'd1, 5'd0, 5'd5), 0);
      issue(mk(0, 0, 1, 0, 0, 1, 3'd0, 5'd2, 5'd3, 5'd0), 0);
      step(nop(), 0, 1);
      step(nop(), 0, 0);
      step(nop(), 0, 0);

      // randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 800; n++) begin
         instr_t d;
         bit r = ($urandom_range(0, 99) < 2);
         d = mk($urandom_range(0, 1), 2'($urandom_range(0, 2)), $urandom_range(0, 1),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)));
         if (r) step(d, $urandom_range(0, 1), 1);
         else   issue(d, $urandom_range(0, 1));
      end

      repeat (2) @(negedge clk);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_pipe.md
HAZARD_CTRL_PIPE -- requirements
Module: hazard_ctrl_pipe

Interface
REQ-001 Parameter: REG_W, default 5, register-address width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  input  1 each  decode-stage controls from the instruction decoder.
REQ-005 ResultSrcD  input  2  write-back select; 2'b01 = load.
REQ-006 ALUControlD  input  3  ALU operation.
REQ-007 Rs1D, Rs2D, RdD  input  REG_W each  decode-stage register addresses.
REQ-008 ZeroE  input  1  ALU zero flag, execute stage.
REQ-009 ALUSrcE  output  1; ALUControlE  output  3  execute-stage controls.
REQ-010 MemWriteM  output  1  memory-stage store enable.
REQ-011 RegWriteW  output  1; ResultSrcW  output  2; RdW  output  REG_W  write-back controls.
REQ-012 PCSrcE  output  1  take branch/jump target.
REQ-013 StallF, StallD, FlushD, FlushE  output  1 each  hazard controls.
REQ-014 ForwardAE, ForwardBE  output  2 each  ALU operand select: 00 regfile, 01 W result, 10 M ALU result.

Function
REQ-015 The block SHALL hold E, M, W pipeline registers for all D controls and Rs1/Rs2/Rd (Rs1/Rs2 in E only); each advances every clock.
REQ-016 PCSrcE SHALL be combinational: (BranchE & ZeroE) | JumpE.
REQ-017 Load-use hazard lwStall SHALL be: ResultSrcE==01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-018 StallF = StallD SHALL be hazard & ~PCSrcE (redirect overrides stall).
REQ-019 FlushD SHALL equal PCSrcE; FlushE SHALL equal hazard | PCSrcE.
REQ-020 When FlushE is high, E registers SHALL load a bubble (all controls and addresses 0) at the next edge; M and W advance normally.
REQ-021 ForwardAE SHALL be 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00; M priority over W. ForwardBE identical using Rs2E.
REQ-022 Register x0 SHALL never cause forward or stall.
REQ-023 Register file writes on the falling edge; no D-stage forwarding or W-vs-D stall is required.
REQ-024 Latency: D control visible at E output 1 cycle later, M 2, W 3, barring bubbles.

Reset
REQ-025 While reset is high at a rising edge, all E/M/W registers SHALL clear to 0; reset mid-operation discards all in-flight instructions.
REQ-026 Immediately after reset: PCSrcE=0, ForwardAE/BE=00, all stall/flush outputs 0 (given benign D inputs).

Configuration
REQ-027 Macro FORWARDING_EN: defined -> forwarding per REQ-021 and hazard = lwStall.
REQ-028 Undefined -> ForwardAE/BE tied 00; hazard = any D source (non-zero) matching RdE with RegWriteE or RdM with RegWriteM.

Structure
REQ-029 Shared package SHALL hold: ResultSrc encodings (ALU 00, LOAD 01, PC4 10), Forward encodings, and a packed control-bundle struct (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUControl).
REQ-030 One sub-module, hazard_unit (combinational: stall, flush, forward), SHALL be instantiated; pipeline registers remain in hazard_ctrl_pipe.

Verification
REQ-031 add x5 then add x6,x5,x1 back-to-back -> cycle 2: ForwardAE=10, no stall (FORWARDING_EN).
REQ-032 add x5; nop; sub x7,x2,x5 -> ForwardBE=01 when sub in E.
REQ-033 lw x5; add x6,x5,x5 -> one cycle StallF=StallD=1, FlushE=1; then ForwardAE=ForwardBE=01.
REQ-034 beq with ZeroE=1 in E -> PCSrcE=1, FlushD=1, FlushE=1; next-cycle E controls all 0.
REQ-035 jal x5 in E while D reads x5, macro undefined -> StallF=0, FlushD=FlushE=1 (redirect wins).
REQ-036 reset asserted with lw in M and store in E -> next cycle MemWriteM=0, RegWriteW=0, RdW=0.
